// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot-control state machine.
package evm_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] LED_IDLE     = 4'b0000;
    localparam logic [3:0] LED_READY    = 4'b0001;
    localparam logic [3:0] LED_SELECTED = 4'b0010;
    localparam logic [3:0] LED_CONFIRM  = 4'b0100;
    localparam logic [3:0] LED_DONE     = 4'b1000;
    localparam logic [3:0] LED_CLOSED   = 4'b1111;

    localparam logic [1:0] VOTE_NONE = 2'b00;
    localparam logic [1:0] VOTE_C1   = 2'b01;
    localparam logic [1:0] VOTE_C2   = 2'b10;
    localparam logic [1:0] VOTE_C3   = 2'b11;

    // State encodings double as the front-panel LED codes.
    typedef enum logic [3:0] {
        S_IDLE     = LED_IDLE,
        S_READY    = LED_READY,
        S_SELECTED = LED_SELECTED,
        S_CONFIRM  = LED_CONFIRM,
        S_DONE     = LED_DONE,
        S_CLOSED   = LED_CLOSED
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

endpackage

// File: rtl/evm_edge_detect.sv
// Single-bit rising-edge detector; the pulse is valid in the cycle the input first reads high.
module evm_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) d_q <= 1'b0;
        else         d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/evm_fsm.sv
// Ballot-control FSM with three candidate tallies and a cancelled-ballot tally.
// Define EVM_DOUBLE_CONFIRM_EN to require two confirm edges per ballot.
module evm_fsm
    import evm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             close,
    input  logic [1:0]       vote,
    input  logic             confirm,
    input  logic             cancel,
    output logic             ready,
    output logic             locked,
    output logic [3:0]       led_state,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3,
    output logic [CNT_W-1:0] count4
);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] cnt3_q, cnt3_d;
    logic [CNT_W-1:0] cnt4_q, cnt4_d;
    logic             conf_e, canc_e;

    evm_edge_detect u_conf_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (confirm),
        .rise_o (conf_e)
    );

    evm_edge_detect u_canc_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (cancel),
        .rise_o (canc_e)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= VOTE_NONE;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            cnt3_q  <= '0;
            cnt4_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            cnt3_q  <= cnt3_d;
            cnt4_q  <= cnt4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        cnt3_d  = cnt3_q;
        cnt4_d  = cnt4_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_READY;
            end

            S_READY: begin
                if (close) begin
                    state_d = S_CLOSED;
                end else if (vote != VOTE_NONE) begin
                    sel_d   = vote;
                    state_d = S_SELECTED;
                end
            end

            S_SELECTED: begin
                if (close) begin
                    state_d = S_CLOSED;
                end else if (canc_e) begin
                    cnt4_d  = sat_inc(cnt4_q);
                    state_d = S_DONE;
                end else if (conf_e) begin
`ifdef EVM_DOUBLE_CONFIRM_EN
                    state_d = S_CONFIRM;
`else
                    unique case (sel_q)
                        VOTE_C1: cnt1_d = sat_inc(cnt1_q);
                        VOTE_C2: cnt2_d = sat_inc(cnt2_q);
                        VOTE_C3: cnt3_d = sat_inc(cnt3_q);
                        default: ;
                    endcase
                    state_d = S_DONE;
`endif
                end else if (vote == VOTE_NONE) begin
                    state_d = S_READY;
                end else begin
                    sel_d = vote;
                end
            end

`ifdef EVM_DOUBLE_CONFIRM_EN
            S_CONFIRM: begin
                if (close) begin
                    state_d = S_CLOSED;
                end else if (canc_e) begin
                    cnt4_d  = sat_inc(cnt4_q);
                    state_d = S_DONE;
                end else if (conf_e) begin
                    unique case (sel_q)
                        VOTE_C1: cnt1_d = sat_inc(cnt1_q);
                        VOTE_C2: cnt2_d = sat_inc(cnt2_q);
                        VOTE_C3: cnt3_d = sat_inc(cnt3_q);
                        default: ;
                    endcase
                    state_d = S_DONE;
                end
            end
`endif

            // Waiting for the selector to return to none stops a held vote recasting.
            S_DONE: begin
                if (close) begin
                    state_d = S_CLOSED;
                end else if (vote == VOTE_NONE) begin
                    state_d = S_READY;
                end
            end

            S_CLOSED: begin
                state_d = S_CLOSED;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == S_READY);
    assign locked    = (state_q == S_IDLE) || (state_q == S_CLOSED);
    assign led_state = state_q;
    assign count1    = cnt1_q;
    assign count2    = cnt2_q;
    assign count3    = cnt3_q;
    assign count4    = cnt4_q;

endmodule

// File: tb/tb_evm_fsm.sv
// Directed self-checking bench for evm_fsm; expectations follow EVM_DOUBLE_CONFIRM_EN when defined.
module tb_evm_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       close;
    logic [1:0] vote;
    logic       confirm;
    logic       cancel;
    logic       ready;
    logic       locked;
    logic [3:0] led_state;
    logic [7:0] count1, count2, count3, count4;

    int errors;
    int checks;

    evm_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .close     (close),
        .vote      (vote),
        .confirm   (confirm),
        .cancel    (cancel),
        .ready     (ready),
        .locked    (locked),
        .led_state (led_state),
        .count1    (count1),
        .count2    (count2),
        .count3    (count3),
        .count4    (count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1; tick(); close = 1'b0;
    endtask

    task automatic press_confirm();
        confirm = 1'b1; tick(); confirm = 1'b0; tick();
    endtask

    task automatic press_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0; tick();
    endtask

    task automatic set_vote(input logic [1:0] v);
        vote = v; tick();
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; close = 1'b0; vote = 2'b00;
        confirm = 1'b0; cancel = 1'b0;
        tick(); tick();
        checks++; if (led_state !== 4'b0000) begin errors++; $display("FAIL reset_led got=%b want=0000", led_state); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL reset_locked got=%b want=1", locked); end
        checks++; if ({count1, count2, count3, count4} !== 32'd0) begin errors++; $display("FAIL reset_counts got=%h want=0", {count1, count2, count3, count4}); end
        reset = 1'b1;
        tick();
        checks++; if (led_state !== 4'b0000) begin errors++; $display("FAIL idle_hold_led got=%b want=0000", led_state); end
    endtask

    task automatic test_vote_c1();
        close = 1'b1; tick(); close = 1'b0;
        checks++; if (led_state !== 4'b0000) begin errors++; $display("FAIL idle_close_ignored got=%b want=0000", led_state); end
        pulse_start();
        checks++; if (ready !== 1'b1 || led_state !== 4'b0001) begin errors++; $display("FAIL start_ready got=%b/%b want=1/0001", ready, led_state); end
        set_vote(2'b01);
        checks++; if (led_state !== 4'b0010) begin errors++; $display("FAIL c1_selected got=%b want=0010", led_state); end
        press_confirm();
`ifdef EVM_DOUBLE_CONFIRM_EN
        checks++; if (led_state !== 4'b0100 || count1 !== 8'd0) begin errors++; $display("FAIL c1_first_conf got=%b/%0d want=0100/0", led_state, count1); end
`else
        checks++; if (led_state !== 4'b1000 || count1 !== 8'd1) begin errors++; $display("FAIL c1_first_conf got=%b/%0d want=1000/1", led_state, count1); end
`endif
        press_confirm();
        checks++; if (led_state !== 4'b1000 || count1 !== 8'd1) begin errors++; $display("FAIL c1_second_conf got=%b/%0d want=1000/1", led_state, count1); end
        set_vote(2'b00);
        checks++; if (ready !== 1'b1 || led_state !== 4'b0001) begin errors++; $display("FAIL c1_back_ready got=%b/%b want=1/0001", ready, led_state); end
        checks++; if ({count2, count3, count4} !== 24'd0) begin errors++; $display("FAIL c1_others got=%h want=0", {count2, count3, count4}); end
    endtask

    task automatic test_vote_c3();
        set_vote(2'b11);
        press_confirm();
        press_confirm();
        checks++; if (count3 !== 8'd1 || led_state !== 4'b1000) begin errors++; $display("FAIL c3_cast got=%0d/%b want=1/1000", count3, led_state); end
        tick(); tick();
        press_confirm();
        press_confirm();
        checks++; if (count3 !== 8'd1 || led_state !== 4'b1000) begin errors++; $display("FAIL c3_held_no_recast got=%0d/%b want=1/1000", count3, led_state); end
        set_vote(2'b00);
        checks++; if (led_state !== 4'b0001 || count1 !== 8'd1) begin errors++; $display("FAIL c3_back_ready got=%b/%0d want=0001/1", led_state, count1); end
    endtask

    task automatic test_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0; tick();
        checks++; if (led_state !== 4'b0001 || count4 !== 8'd0) begin errors++; $display("FAIL ready_cancel_ignored got=%b/%0d want=0001/0", led_state, count4); end
        set_vote(2'b01);
        set_vote(2'b10);
        press_cancel();
        checks++; if (count4 !== 8'd1 || count2 !== 8'd0 || count1 !== 8'd1) begin errors++; $display("FAIL cancel_counts got=%0d/%0d/%0d want=1/0/1", count4, count2, count1); end
        checks++; if (led_state !== 4'b1000) begin errors++; $display("FAIL cancel_done got=%b want=1000", led_state); end
        set_vote(2'b00);
        checks++; if (led_state !== 4'b0001) begin errors++; $display("FAIL cancel_back_ready got=%b want=0001", led_state); end
        set_vote(2'b10);
        set_vote(2'b00);
        checks++; if (led_state !== 4'b0001 || count2 !== 8'd0) begin errors++; $display("FAIL deselect_ready got=%b/%0d want=0001/0", led_state, count2); end
    endtask

    task automatic test_hold_confirm();
        set_vote(2'b01);
        confirm = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        confirm = 1'b0;
`ifdef EVM_DOUBLE_CONFIRM_EN
        checks++; if (led_state !== 4'b0100 || count1 !== 8'd1) begin errors++; $display("FAIL hold_conf_once got=%b/%0d want=0100/1", led_state, count1); end
        tick();
        press_confirm();
`else
        checks++; if (led_state !== 4'b1000 || count1 !== 8'd2) begin errors++; $display("FAIL hold_conf_once got=%b/%0d want=1000/2", led_state, count1); end
        tick();
`endif
        checks++; if (count1 !== 8'd2 || led_state !== 4'b1000) begin errors++; $display("FAIL hold_conf_cast got=%0d/%b want=2/1000", count1, led_state); end
        set_vote(2'b00);
    endtask

    task automatic test_close();
        set_vote(2'b10);
`ifdef EVM_DOUBLE_CONFIRM_EN
        press_confirm();
        checks++; if (led_state !== 4'b0100) begin errors++; $display("FAIL close_pre_confirm got=%b want=0100", led_state); end
`endif
        pulse_close();
        checks++; if (led_state !== 4'b1111 || locked !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL close_state got=%b/%b/%b want=1111/1/0", led_state, locked, ready); end
        checks++; if ({count1, count2, count3, count4} !== {8'd2, 8'd0, 8'd1, 8'd1}) begin errors++; $display("FAIL close_counts got=%h want=02000101", {count1, count2, count3, count4}); end
        pulse_start();
        set_vote(2'b10);
        press_confirm();
        press_confirm();
        press_cancel();
        set_vote(2'b00);
        checks++; if (led_state !== 4'b1111 || {count1, count2, count3, count4} !== {8'd2, 8'd0, 8'd1, 8'd1}) begin errors++; $display("FAIL closed_terminal got=%b/%h want=1111/02000101", led_state, {count1, count2, count3, count4}); end
    endtask

    task automatic test_reset_mid();
        hard_reset();
        pulse_start();
        set_vote(2'b01);
        press_confirm();
`ifdef EVM_DOUBLE_CONFIRM_EN
        checks++; if (led_state !== 4'b0100 || count1 !== 8'd0) begin errors++; $display("FAIL mid_pre got=%b/%0d want=0100/0", led_state, count1); end
`else
        checks++; if (led_state !== 4'b1000 || count1 !== 8'd1) begin errors++; $display("FAIL mid_single_conf got=%b/%0d want=1000/1", led_state, count1); end
`endif
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({count1, count2, count3, count4} !== 32'd0) begin errors++; $display("FAIL mid_reset_counts got=%h want=0", {count1, count2, count3, count4}); end
        checks++; if (led_state !== 4'b0000 || locked !== 1'b1) begin errors++; $display("FAIL mid_reset_state got=%b/%b want=0000/1", led_state, locked); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int n = 0; n < 256; n++) begin
            set_vote(2'b01);
            press_confirm();
`ifdef EVM_DOUBLE_CONFIRM_EN
            press_confirm();
`endif
            if (n == 254) begin
                checks++; if (count1 !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d want=255", count1); end
            end
            if (n == 255) begin
                checks++; if (count1 !== 8'd255 || led_state !== 4'b1000) begin errors++; $display("FAIL sat_hold got=%0d/%b want=255/1000", count1, led_state); end
            end
            set_vote(2'b00);
        end
        checks++; if (led_state !== 4'b0001 || {count2, count3, count4} !== 24'd0) begin errors++; $display("FAIL sat_after got=%b/%h want=0001/0", led_state, {count2, count3, count4}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_vote_c1();
        test_vote_c3();
        test_cancel();
        test_hold_confirm();
        test_close();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
